// File: rtl/adc_regs_pkg.sv
// adc_regs_pkg: register map, gain codes and sequencer state encoding
// shared by the ADC register block and its Avalon-MM sequencer.
package adc_regs_pkg;
    localparam int REG_LED      = 0;
    localparam int REG_ADC_EN   = 1;
    localparam int REG_CHA      = 2;
    localparam int REG_CHB      = 3;
    localparam int REG_GAIN_A   = 4;
    localparam int REG_GAIN_B   = 5;
    localparam int REG_SIG_EN   = 6;
    localparam int REG_SIG_F    = 7;
    localparam int REG_LED_MODE = 8;
    localparam int GAIN_2X   = 0;
    localparam int GAIN_3P5X = 1;
    localparam int GAIN_8P5X = 2;
    typedef enum logic [2:0] {IDLE, CFG, POLL_WAIT, RD_A, RD_B, CAP_B} state_e;
    function automatic logic polling(input state_e s);
        return s inside {POLL_WAIT, RD_A, RD_B, CAP_B};
    endfunction
endpackage

// File: rtl/adc_poll_timer.sv
// adc_poll_timer: wrapping 0..DIV-1 divider; tc_o marks the pair-start slot
// (count at 0). Dropping run_i clears the count.
module adc_poll_timer #(
    parameter int DIV = 16
) (
    input  logic main_clk,
    input  logic rst,
    input  logic run_i,
    output logic tc_o
);
    localparam int W = $clog2(DIV);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = run_i ? ((cnt_q == W'(DIV - 1)) ? '0 : cnt_q + 1'b1) : '0;
    always_ff @(posedge main_clk or negedge rst)
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    assign tc_o = (cnt_q == '0);
endmodule

// File: rtl/adc_mm_sequencer.sv
// adc_mm_sequencer: Avalon-MM initiator that bursts the configuration
// registers on request and polls the A/B sample registers in pairs.
module adc_mm_sequencer
    import adc_regs_pkg::*;
#(
    parameter int POLL_DIV = 16,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 16
) (
    input  logic              main_clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] address,
    output logic              read,
    output logic              write,
    output logic [DATA_W-1:0] writedata,
    input  logic [DATA_W-1:0] readdata,
    input  logic              cfg_start,
    input  logic [1:0]        gain_a,
    input  logic [1:0]        gain_b,
    input  logic              siggen_en,
    input  logic              siggen_freq,
    input  logic [1:0]        led_mode,
    input  logic              poll_en,
    output logic [7:0]        sample_a,
    output logic [7:0]        sample_b,
    output logic              sample_valid,
    output logic              cfg_done,
    output logic              busy
);
    state_e     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic       pend_q, pend_d;
    logic [1:0] gain_a_q, gain_b_q, led_q, fld;
    logic       sig_en_q, sig_f_q;
    logic [7:0] hold_q, sample_a_q, sample_b_q;
    logic       valid_q, done_q, tc, cfg_take, unused_hi;

    assign unused_hi = ^readdata[DATA_W-1:8];
    assign cfg_take  = cfg_start && state_q != CFG;

    adc_poll_timer #(.DIV(POLL_DIV)) u_timer (
        .main_clk (main_clk),
        .rst      (rst),
        .run_i    (polling(state_q) && polling(state_d)),
        .tc_o     (tc)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      state_d = cfg_start ? CFG : poll_en ? POLL_WAIT : IDLE;
            CFG:       state_d = (idx_q != 3'd4) ? CFG : poll_en ? POLL_WAIT : IDLE;
            POLL_WAIT: state_d = cfg_start ? CFG : !poll_en ? IDLE : tc ? RD_A : POLL_WAIT;
            RD_A:      state_d = RD_B;
            RD_B:      state_d = CAP_B;
            CAP_B:     state_d = (pend_q || cfg_start) ? CFG : !poll_en ? IDLE : tc ? RD_A : POLL_WAIT;
            default:   state_d = IDLE;
        endcase
        idx_d  = (state_q == CFG && idx_q != 3'd4) ? idx_q + 3'd1 : 3'd0;
        pend_d = (state_q == RD_A || state_q == RD_B) && (pend_q || cfg_start);
    end

    always_comb begin
        write     = state_q == CFG;
        read      = state_q == RD_A || state_q == RD_B;
        busy      = write || read || state_q == CAP_B;
        fld       = idx_q == 3'd0 ? gain_a_q : idx_q == 3'd1 ? gain_b_q :
                    idx_q == 3'd2 ? {1'b0, sig_en_q} : idx_q == 3'd3 ? {1'b0, sig_f_q} : led_q;
        writedata = write ? DATA_W'(fld) : '0;
        address   = write ? ADDR_W'(REG_GAIN_A + int'(idx_q)) :
                    state_q == RD_A ? ADDR_W'(REG_CHA) :
                    state_q == RD_B ? ADDR_W'(REG_CHB) : '0;
    end

    always_ff @(posedge main_clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            pend_q     <= 1'b0;
            gain_a_q   <= '0;
            gain_b_q   <= '0;
            led_q      <= '0;
            sig_en_q   <= 1'b0;
            sig_f_q    <= 1'b0;
            hold_q     <= '0;
            sample_a_q <= '0;
            sample_b_q <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            valid_q <= state_q == CAP_B;
            done_q  <= state_q == CFG && idx_q == 3'd4;
            if (cfg_take) begin
                gain_a_q <= gain_a;
                gain_b_q <= gain_b;
                led_q    <= led_mode;
                sig_en_q <= siggen_en;
                sig_f_q  <= siggen_freq;
            end
            // A lands one cycle after its read, i.e. while B is being requested
            if (state_q == RD_B) hold_q <= readdata[7:0];
            if (state_q == CAP_B) begin
                sample_a_q <= hold_q;
                sample_b_q <= readdata[7:0];
            end
        end
    end

    assign sample_a     = sample_a_q;
    assign sample_b     = sample_b_q;
    assign sample_valid = valid_q;
    assign cfg_done     = done_q;
endmodule

// File: tb/tb_adc_mm_sequencer.sv
// tb_adc_mm_sequencer: directed checks of the sequencer against a simple
// register-block responder; a second instance runs with POLL_DIV=3.
module tb_adc_mm_sequencer;
    logic        main_clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  address, address3;
    logic        read, write, read3, write3;
    logic [15:0] writedata, writedata3;
    logic [15:0] readdata = '0, readdata3 = '0;
    logic        cfg_start = 1'b0;
    logic [1:0]  gain_a = '0, gain_b = '0, led_mode = '0;
    logic        siggen_en = 1'b0, siggen_freq = 1'b0;
    logic        poll_en = 1'b0, poll_en3 = 1'b0;
    logic [7:0]  sample_a, sample_b, sample_a3, sample_b3;
    logic        sample_valid, cfg_done, busy, sample_valid3, cfg_done3, busy3;
    logic [7:0]  reg_a = 8'h5A, reg_b = 8'hC3;
    int          n_cmp = 0, n_err = 0;

    always #5 main_clk = ~main_clk;

    adc_mm_sequencer dut (
        .main_clk(main_clk), .rst(rst), .address(address), .read(read), .write(write),
        .writedata(writedata), .readdata(readdata), .cfg_start(cfg_start),
        .gain_a(gain_a), .gain_b(gain_b), .siggen_en(siggen_en), .siggen_freq(siggen_freq),
        .led_mode(led_mode), .poll_en(poll_en), .sample_a(sample_a), .sample_b(sample_b),
        .sample_valid(sample_valid), .cfg_done(cfg_done), .busy(busy)
    );

    adc_mm_sequencer #(.POLL_DIV(3)) dut3 (
        .main_clk(main_clk), .rst(rst), .address(address3), .read(read3), .write(write3),
        .writedata(writedata3), .readdata(readdata3), .cfg_start(1'b0),
        .gain_a(2'b00), .gain_b(2'b00), .siggen_en(1'b0), .siggen_freq(1'b0),
        .led_mode(2'b00), .poll_en(poll_en3), .sample_a(sample_a3), .sample_b(sample_b3),
        .sample_valid(sample_valid3), .cfg_done(cfg_done3), .busy(busy3)
    );

    always @(posedge main_clk) begin
        if (read)  readdata  <= {8'hAB, address == 5'd2 ? reg_a : address == 5'd3 ? reg_b : 8'h00};
        if (read3) readdata3 <= {8'hFF, address3 == 5'd2 ? 8'hA5 : address3 == 5'd3 ? 8'h3C : 8'h00};
    end

    task automatic step(input int n);
        repeat (n) @(negedge main_clk);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [15:0] wd1 [5] = '{16'd2, 16'd1, 16'd1, 16'd0, 16'd1};
        logic [15:0] wd2 [5] = '{16'd3, 16'd0, 16'd0, 16'd1, 16'd2};
        int cnt;
        step(2);
        chk("rst_address", 16'(address), 16'd0);
        chk("rst_read", 16'(read), 16'd0);
        chk("rst_write", 16'(write), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_cfg_done", 16'(cfg_done), 16'd0);
        chk("rst_valid", 16'(sample_valid), 16'd0);
        chk("rst_sample_a", 16'(sample_a), 16'd0);
        rst = 1'b1;
        step(2);
        // configuration burst; inputs are scrambled after the latch cycle
        {gain_a, gain_b, siggen_en, siggen_freq, led_mode} = {2'd2, 2'd1, 1'b1, 1'b0, 2'd1};
        cfg_start = 1'b1;
        step(1);
        cfg_start = 1'b0;
        {gain_a, gain_b, siggen_en, siggen_freq, led_mode} = '0;
        for (int i = 0; i < 5; i++) begin
            chk("cfg1_write", 16'(write), 16'd1);
            chk("cfg1_read", 16'(read), 16'd0);
            chk("cfg1_addr", 16'(address), 16'(4 + i));
            chk("cfg1_data", writedata, wd1[i]);
            chk("cfg1_done_early", 16'(cfg_done), 16'd0);
            step(1);
        end
        chk("cfg1_done", 16'(cfg_done), 16'd1);
        chk("cfg1_write_off", 16'(write), 16'd0);
        chk("cfg1_addr_idle", 16'(address), 16'd0);
        step(1);
        chk("cfg1_done_pulse", 16'(cfg_done), 16'd0);
        // polling with POLL_DIV=16
        poll_en = 1'b1;
        step(1);
        chk("poll_wait_read", 16'(read), 16'd0);
        step(1);
        chk("rda_read", 16'(read), 16'd1);
        chk("rda_addr", 16'(address), 16'd2);
        chk("rda_busy", 16'(busy), 16'd1);
        step(1);
        chk("rdb_read", 16'(read), 16'd1);
        chk("rdb_addr", 16'(address), 16'd3);
        step(1);
        chk("capb_read", 16'(read), 16'd0);
        chk("capb_busy", 16'(busy), 16'd1);
        chk("capb_valid", 16'(sample_valid), 16'd0);
        step(1);
        chk("pair1_valid", 16'(sample_valid), 16'd1);
        chk("pair1_a", 16'(sample_a), 16'h5A);
        chk("pair1_b", 16'(sample_b), 16'hC3);
        chk("pair1_busy", 16'(busy), 16'd0);
        reg_a = 8'h11;
        reg_b = 8'h22;
        step(12);
        chk("period_pre_read", 16'(read), 16'd0);
        step(1);
        chk("period_read", 16'(read), 16'd1);
        chk("period_addr", 16'(address), 16'd2);
        // cfg_start during RD_A: held until the pair completes
        {gain_a, gain_b, siggen_en, siggen_freq, led_mode} = {2'd3, 2'd0, 1'b0, 1'b1, 2'd2};
        cfg_start = 1'b1;
        step(1);
        cfg_start = 1'b0;
        chk("pend_rdb_addr", 16'(address), 16'd3);
        chk("pend_rdb_write", 16'(write), 16'd0);
        step(1);
        chk("pend_capb_write", 16'(write), 16'd0);
        chk("pend_capb_busy", 16'(busy), 16'd1);
        reg_a = 8'h33;
        reg_b = 8'h44;
        step(1);
        chk("pend_valid", 16'(sample_valid), 16'd1);
        chk("pend_a", 16'(sample_a), 16'h11);
        chk("pend_b", 16'(sample_b), 16'h22);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step(1);
            chk("cfg2_write", 16'(write), 16'd1);
            chk("cfg2_addr", 16'(address), 16'(4 + i));
            chk("cfg2_data", writedata, wd2[i]);
        end
        step(1);
        chk("cfg2_done", 16'(cfg_done), 16'd1);
        chk("cfg2_read", 16'(read), 16'd0);
        step(1);
        chk("resume_read", 16'(read), 16'd1);
        chk("resume_addr", 16'(address), 16'd2);
        // poll_en dropped in RD_B: pair completes, then idle
        step(1);
        poll_en = 1'b0;
        chk("drop_rdb_addr", 16'(address), 16'd3);
        step(1);
        chk("drop_capb_busy", 16'(busy), 16'd1);
        step(1);
        chk("drop_valid", 16'(sample_valid), 16'd1);
        chk("drop_a", 16'(sample_a), 16'h33);
        chk("drop_b", 16'(sample_b), 16'h44);
        chk("drop_busy", 16'(busy), 16'd0);
        cnt = 0;
        repeat (20) begin
            step(1);
            if (read) cnt++;
        end
        chk("drop_no_reads", 16'(cnt), 16'd0);
        // reset during the third configuration write
        {gain_a, gain_b, siggen_en, siggen_freq, led_mode} = {2'd1, 2'd2, 1'b1, 1'b1, 2'd0};
        cfg_start = 1'b1;
        step(1);
        cfg_start = 1'b0;
        chk("rstcfg_addr0", 16'(address), 16'd4);
        step(2);
        chk("rstcfg_write3", 16'(write), 16'd1);
        chk("rstcfg_addr3", 16'(address), 16'd6);
        #1 rst = 1'b0;
        #1;
        chk("rstcfg_write", 16'(write), 16'd0);
        chk("rstcfg_addr", 16'(address), 16'd0);
        chk("rstcfg_busy", 16'(busy), 16'd0);
        chk("rstcfg_done", 16'(cfg_done), 16'd0);
        chk("rstcfg_wdata", writedata, 16'd0);
        step(1);
        rst = 1'b1;
        cnt = 0;
        repeat (12) begin
            step(1);
            if (write || cfg_done) cnt++;
        end
        chk("rstcfg_no_resume", 16'(cnt), 16'd0);
        // POLL_DIV=3: back-to-back pairs, low byte only
        poll_en3 = 1'b1;
        step(1);
        chk("p3_wait_read", 16'(read3), 16'd0);
        step(1);
        chk("p3_rda_read", 16'(read3), 16'd1);
        chk("p3_rda_addr", 16'(address3), 16'd2);
        step(1);
        chk("p3_rdb_addr", 16'(address3), 16'd3);
        step(1);
        chk("p3_capb_read", 16'(read3), 16'd0);
        chk("p3_capb_busy", 16'(busy3), 16'd1);
        step(1);
        chk("p3_b2b_read", 16'(read3), 16'd1);
        chk("p3_b2b_addr", 16'(address3), 16'd2);
        chk("p3_valid", 16'(sample_valid3), 16'd1);
        chk("p3_a", 16'(sample_a3), 16'hA5);
        chk("p3_b", 16'(sample_b3), 16'h3C);
        step(3);
        chk("p3_b2b2_read", 16'(read3), 16'd1);
        chk("p3_valid2", 16'(sample_valid3), 16'd1);
        poll_en3 = 1'b0;
        step(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/adc_mm_sequencer.md
Name: adc_mm_sequencer

Overview:
- Avalon-MM initiator that drives the ADC board register block; it is the master end of the same 5-bit-address, 16-bit-data bus.
- On a configuration request it writes the gain, signal-generator and LED-mode registers as one burst of single-cycle writes.
- It then polls the channel A and channel B sample registers at a fixed rate and presents each A/B pair on a valid-strobed output.
- Sits between the system control logic or demodulator front end and the ADC register block, all on main_clk.

Parameters:
- POLL_DIV, 16: main_clk cycles between poll-pair starts; legal range 3..65535.
- ADDR_W, 5: Avalon address width.
- DATA_W, 16: Avalon data width.

Ports:
- main_clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- address  out  ADDR_W  Avalon address.
- read  out  1  Avalon read strobe; single cycle.
- write  out  1  Avalon write strobe; single cycle.
- writedata  out  DATA_W  Avalon write data.
- readdata  in  DATA_W  Avalon read data; valid exactly 1 cycle after read, no waitrequest.
- cfg_start  in  1  pulse that requests a configuration burst.
- gain_a  in  2  channel A gain code (0 = 2x, 1 = 3.5x, 2 = 8.5x).
- gain_b  in  2  channel B gain code.
- siggen_en  in  1  on-board signal generator enable.
- siggen_freq  in  1  generator frequency select (0 = 2.5 MHz, 1 = 5 MHz).
- led_mode  in  2  LED source select (0 = register, 1 = channel A, 2 = channel B).
- poll_en  in  1  level; enables sample polling.
- sample_a  out  8  last channel A sample.
- sample_b  out  8  last channel B sample.
- sample_valid  out  1  1-cycle pulse when sample_a and sample_b update together.
- cfg_done  out  1  1-cycle pulse after the last configuration write.
- busy  out  1  high while a configuration burst or poll pair is in flight.

Behaviour:
- Reset values: every output is 0, the FSM is in IDLE and the divider is 0. Assertion of rst acts immediately, including mid-burst or mid-pair; no transaction resumes after reset.
- FSM states: IDLE, CFG, POLL_WAIT, RD_A, RD_B, CAP_B.
- cfg_start handling:
  - On cfg_start, the values of gain_a, gain_b, siggen_en, siggen_freq and led_mode are latched in the same cycle.
  - The FSM enters CFG, where write=1 for 5 consecutive cycles with address = 4, 5, 6, 7, 8 in that order.
  - writedata carries the latched field zero-extended to DATA_W.
  - cfg_done pulses in the cycle after the address-8 write. The FSM then goes to POLL_WAIT if poll_en is high, otherwise IDLE.
- Poll timing:
  - The divider counts 0..POLL_DIV-1 while the FSM is in POLL_WAIT, RD_A, RD_B or CAP_B, and wraps to 0.
  - When the divider is at 0 in POLL_WAIT with poll_en high, the FSM moves to RD_A.
- Poll pair, cycle by cycle:
  - RD_A: read=1, address=2.
  - RD_B: read=1, address=3; capture readdata[7:0] into a holding register for A.
  - CAP_B: sample_b <= readdata[7:0], sample_a <= holding register, sample_valid=1 in the following cycle.
  - Read latency from RD_A to sample_valid is 3 cycles.
  - sample_a and sample_b never update separately.
- read and write are never high in the same cycle. address returns to 0 whenever read and write are both low.
- busy is high in CFG, RD_A, RD_B and CAP_B.
- Boundary conditions:
  - cfg_start during CFG is ignored.
  - cfg_start during a poll pair is held pending. The burst starts in the cycle after CAP_B, and the divider resets to 0 when polling resumes.
  - cfg_start in POLL_WAIT starts CFG in the next cycle.
  - cfg_start and poll pair-start in the same cycle: CFG wins.
  - poll_en falling mid-pair: the pair completes, then the FSM goes to IDLE.
  - poll_en falling in POLL_WAIT: IDLE in the next cycle, divider cleared.
  - poll_en rising in IDLE: POLL_WAIT with the divider at 0, so the first RD_A comes 1 cycle later.
  - Gain code 3 is written as-is; decoding is the register block's job.
- Only readdata[7:0] is used; readdata[15:8] is ignored.

Decomposition:
- Shared package adc_regs_pkg holds:
  - register address constants: REG_LED=0, REG_ADC_EN=1, REG_CHA=2, REG_CHB=3, REG_GAIN_A=4, REG_GAIN_B=5, REG_SIG_EN=6, REG_SIG_F=7, REG_LED_MODE=8;
  - gain codes GAIN_2X=0, GAIN_3P5X=1, GAIN_8P5X=2;
  - the FSM state enum.
- One sub-module is natural: adc_poll_timer, the POLL_DIV divider with clear and terminal-count output.

Test Plan:
- Reset then cfg_start with gain_a=2, gain_b=1, siggen_en=1, siggen_freq=0, led_mode=1 -> writes (4,2), (5,1), (6,1), (7,0), (8,1) on 5 consecutive cycles; cfg_done 1 cycle later; read stays low.
- poll_en=1 with a register model returning 0x5A at address 2 and 0xC3 at address 3 -> read at address 2, then address 3; sample_valid 3 cycles after the first read with sample_a=0x5A, sample_b=0xC3; pairs repeat every 16 cycles.
- cfg_start asserted in the RD_A cycle -> the pair completes and sample_valid fires, then the 5 writes start the next cycle; polling resumes with the divider at 0.
- poll_en dropped in the RD_B cycle -> sample_valid still fires, no further reads, busy=0.
- rst asserted during the third configuration write -> write, address, busy and cfg_done go to 0 immediately; after release no write occurs without a new cfg_start.
- POLL_DIV=3 with readdata upper byte 0xFF -> back-to-back pairs with no idle cycle; samples use the low byte only.
